alu_req_arbiter: RTL and testbench

//  Shares the single-cycle integer ALU among NUM_REQ requesters (e.g. main datapath, address-gen, debug).

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_req_arbiter_if.sv | 38 +++
 rtl/alu.sv | 42 ++++
 rtl/rr_arb.sv | 43 ++++
 rtl/alu_req_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_req_arbiter.sv | 299 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU request arbiter slice.
//   alu_op_e     4-bit ALU operation codes (0..9 legal, 10..15 illegal)
//   ALU_OP_LAST  highest legal operation code
//   arb_state_e  arbiter FSM states
//   XLEN         datapath width
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    localparam logic [3:0] ALU_OP_LAST = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= ALU_OP_LAST);
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter_if
// Request/response bundle between the requesting units (master) and the
// ALU arbiter (slave).
//   i_req_valid / o_req_ready          per-requester request handshake
//   i_req_operand_a/b, i_req_alu_op    per-requester operands and op code
//   o_rsp_valid / i_rsp_ready          response handshake
//   o_rsp_id, o_rsp_data, o_rsp_illegal response payload
//   o_grant_cnt                        per-requester grant counters
// -----------------------------------------------------------------------------
interface alu_req_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ-1:0]            o_req_ready;
    logic [NUM_REQ-1:0][XLEN-1:0]  i_req_operand_a;
    logic [NUM_REQ-1:0][XLEN-1:0]  i_req_operand_b;
    logic [NUM_REQ-1:0][3:0]       i_req_alu_op;
    logic                          o_rsp_valid;
    logic                          i_rsp_ready;
    logic [ID_W-1:0]               o_rsp_id;
    logic [XLEN-1:0]               o_rsp_data;
    logic                          o_rsp_illegal;
    logic [NUM_REQ-1:0][15:0]      o_grant_cnt;

    modport master (
        output i_req_valid, i_req_operand_a, i_req_operand_b, i_req_alu_op, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_illegal, o_grant_cnt
    );

    modport slave (
        input  i_req_valid, i_req_operand_a, i_req_operand_b, i_req_alu_op, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_illegal, o_grant_cnt
    );
endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Single-cycle combinational integer ALU.
//   op_i       operation code (alu_op_e); codes above ALU_OP_LAST are illegal
//   a_i, b_i   operands; shifts use b_i[4:0]
//   result_o   result, 0 for illegal codes
//   illegal_o  high for illegal codes
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            illegal_o
);
    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        if (!op_is_legal(op_i)) begin
            illegal_o = 1'b1;
        end else begin
            case (alu_op_e'(op_i))
                ALU_ADD:  result_o = a_i + b_i;
                ALU_SUB:  result_o = a_i - b_i;
                ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
                ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
                ALU_XOR:  result_o = a_i ^ b_i;
                ALU_OR:   result_o = a_i | b_i;
                ALU_AND:  result_o = a_i & b_i;
                ALU_SLL:  result_o = a_i << shamt;
                ALU_SRL:  result_o = a_i >> shamt;
                ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
                default:  result_o = '0;
            endcase
        end
    end
endmodule

// File: rtl/rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Round-robin request picker: first set request searching ptr, ptr+1, ...
// (mod NUM_REQ). Produces nothing while en_i is low.
//   req_i  request vector        ptr_i  highest-priority index
//   en_i   allow a grant         gnt_o  one-hot grant (or zero)
//   idx_o  granted index         any_o  a grant was made
// -----------------------------------------------------------------------------
module rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);
    always_comb begin
        int         j;
        logic [ID_W-1:0] cand;
        logic       found;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        cand  = '0;
        found = 1'b0;
        if (en_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                j    = (int'(ptr_i) + k) % NUM_REQ;
                cand = ID_W'(j);
                if (!found && req_i[cand]) begin
                    found       = 1'b1;
                    gnt_o[cand] = 1'b1;
                    idx_o       = cand;
                end
            end
        end
        any_o = found;
    end
endmodule

// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
// Shares one ALU among NUM_REQ requesters with round-robin arbitration.
// The result is registered: a request accepted in cycle N is presented in
// cycle N+1; a consume and a new grant may happen in the same cycle.
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      alu_req_arbiter_if.slave (request, response, grant counters)
// Build option: define ALU_ARB_PERF_EN to build saturating per-requester
// grant counters; otherwise o_grant_cnt is tied to zero.
//
// state | meaning
// IDLE  | no response held, any valid request is granted
// RESP  | response presented; new grant only when it is consumed this cycle
// -----------------------------------------------------------------------------
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    alu_req_arbiter_if.slave   bus
);
    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_illegal_q, rsp_illegal_d;

    logic              can_accept;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;
    logic [XLEN-1:0]   sel_a, sel_b, alu_res;
    logic [3:0]        sel_op;
    logic              alu_ill;

    assign can_accept = (state_q == IDLE) || bus.i_rsp_ready;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arb (
        .req_i (bus.i_req_valid),
        .ptr_i (ptr_q),
        .en_i  (can_accept),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign sel_a  = bus.i_req_operand_a[gnt_idx];
    assign sel_b  = bus.i_req_operand_b[gnt_idx];
    assign sel_op = bus.i_req_alu_op[gnt_idx];

    alu u_alu (
        .op_i      (sel_op),
        .a_i       (sel_a),
        .b_i       (sel_b),
        .result_o  (alu_res),
        .illegal_o (alu_ill)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            IDLE: if (gnt_any) state_d = RESP;
            RESP: if (!gnt_any && bus.i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (gnt_any) begin
            rsp_id_d      = gnt_idx;
            rsp_data_d    = alu_res;
            rsp_illegal_d = alu_ill;
            ptr_d         = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            rsp_id_q      <= '0;
            rsp_data_q    <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign bus.o_req_ready   = gnt;
    assign bus.o_rsp_valid   = (state_q == RESP);
    assign bus.o_rsp_id      = rsp_id_q;
    assign bus.o_rsp_data    = rsp_data_q;
    assign bus.o_rsp_illegal = rsp_illegal_q;

`ifdef ALU_ARB_PERF_EN
    logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && (cnt_q[i] != 16'hFFFF)) cnt_d[i] = cnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign bus.o_grant_cnt = cnt_q;
`else
    assign bus.o_grant_cnt = '0;
`endif

    // A requester must hold valid until it is granted.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_hold
        a_req_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (bus.i_req_valid[gi] && !bus.o_req_ready[gi]) |=> bus.i_req_valid[gi]);
    end
endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int N   = 2;
    localparam int IDW = 1;

    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; } req_t;
    typedef struct { int id; logic [31:0] data; logic ill; } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    alu_req_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

    alu_req_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    req_t    rq [N][$];
    rsp_t    exp_q[$];
    int      checks   = 0;
    int      failures = 0;
    int      m_ptr    = 0;
    int      m_busy   = 0;
    longint  m_cnt [N];
    logic    drv_ready = 1'b1;

    bit          hold   = 0;
    logic [31:0] h_data;
    logic [IDW-1:0] h_id;
    logic        h_ill;

    // Reference ALU, written from the op definitions with plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, output logic ill);
        int sh;
        logic [31:0] fill;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        case (int'(op))
            0: return a + b;
            1: return a + (~b) + 32'd1;
            2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return a | b;
            6: return a & b;
            7: return a << sh;
            8: return a >> sh;
            9: begin
                fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (a >> sh) | fill;
            end
            default: begin
                ill = 1'b1;
                return 32'd0;
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic drive();
        logic [IDW-1:0] ii;
        for (int i = 0; i < N; i++) begin
            ii = IDW'(i);
            if (rq[i].size() > 0) begin
                bus.i_req_valid[ii]     = 1'b1;
                bus.i_req_operand_a[ii] = rq[i][0].a;
                bus.i_req_operand_b[ii] = rq[i][0].b;
                bus.i_req_alu_op[ii]    = rq[i][0].op;
            end else begin
                bus.i_req_valid[ii]     = 1'b0;
                bus.i_req_operand_a[ii] = $urandom;
                bus.i_req_operand_b[ii] = $urandom;
                bus.i_req_alu_op[ii]    = 4'($urandom_range(0, 15));
            end
        end
        bus.i_rsp_ready = drv_ready;
    endtask

    // One clock: drive at the falling edge, then predict this cycle's grant.
    task automatic step();
        int   g;
        int   j;
        bit   can;
        req_t r;
        logic [31:0] d;
        logic il;
        @(negedge clk);
        drive();
        #1;
        check("rsp_valid", 64'(bus.o_rsp_valid), 64'(m_busy));
        can = (m_busy == 0) || drv_ready;
        g   = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && rq[j].size() > 0) g = j;
            end
        end
        check("req_ready", 64'(bus.o_req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
            r = rq[g].pop_front();
            d = ref_alu(r.op, r.a, r.b, il);
            exp_q.push_back('{id: g, data: d, ill: il});
            m_ptr  = (g + 1) % N;
            m_busy = 1;
            m_cnt[g]++;
        end else if (drv_ready) begin
            m_busy = 0;
        end
    endtask

    task automatic push(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        rq[i].push_back('{a: a, b: b, op: op});
    endtask

    task automatic drain();
        int n = 0;
        drv_ready = 1'b1;
        while ((rq[0].size() + rq[1].size() > 0 || m_busy != 0) && n < 40) begin
            step();
            n++;
        end
        step();
        #2;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.o_rsp_data), 64'd0);
        check("rst_rsp_id", 64'(bus.o_rsp_id), 64'd0);
        check("rst_rsp_illegal", 64'(bus.o_rsp_illegal), 64'd0);
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            m_cnt[i] = 0;
        end
        exp_q.delete();
        hold   = 0;
        m_ptr  = 0;
        m_busy = 0;
        bus.i_req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: consumes responses on handshake and checks held outputs.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 0;
            end else begin
                if (hold) begin
                    check("hold_valid", 64'(bus.o_rsp_valid), 64'd1);
                    check("hold_payload", {31'd0, bus.o_rsp_id, bus.o_rsp_data},
                          {31'd0, h_id, h_data});
                    check("hold_illegal", 64'(bus.o_rsp_illegal), 64'(h_ill));
                end
                if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                    hold = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected actual id=%0d data=%0h required=none",
                                 bus.o_rsp_id, bus.o_rsp_data);
                    end else begin
                        rsp_t e;
                        e = exp_q.pop_front();
                        check("rsp_id", 64'(bus.o_rsp_id), 64'(e.id));
                        check("rsp_data", 64'(bus.o_rsp_data), 64'(e.data));
                        check("rsp_illegal", 64'(bus.o_rsp_illegal), 64'(e.ill));
                    end
                end else if (bus.o_rsp_valid) begin
                    hold   = 1;
                    h_id   = bus.o_rsp_id;
                    h_data = bus.o_rsp_data;
                    h_ill  = bus.o_rsp_illegal;
                end else begin
                    hold = 0;
                end
            end
        end
    end

    initial begin
        logic [63:0] exp_cnt;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        bus.i_req_valid     = '0;
        bus.i_req_operand_a = '0;
        bus.i_req_operand_b = '0;
        bus.i_req_alu_op    = '0;
        bus.i_rsp_ready     = 1'b1;

        #1 rst_n = 1'b0;
        #2;
        check("reset_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("reset_rsp_id", 64'(bus.o_rsp_id), 64'd0);
        check("reset_rsp_data", 64'(bus.o_rsp_data), 64'd0);
        check("reset_rsp_illegal", 64'(bus.o_rsp_illegal), 64'd0);
        check("reset_req_ready", 64'(bus.o_req_ready), 64'd0);
        check("reset_grant_cnt", 64'(bus.o_grant_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request, immediate ready and one-cycle latency.
        drv_ready = 1'b1;
        push(0, 32'd5, 32'd3, 4'd0);
        step();
        step();

        // Two requesters contending: strict alternation, back-to-back.
        for (int k = 0; k < 4; k++) begin
            push(0, $urandom, $urandom, 4'($urandom_range(0, 9)));
            push(1, $urandom, $urandom, 4'($urandom_range(0, 9)));
        end
        repeat (9) step();

        // Stalled consumer: response held, no new grants.
        push(1, 32'h8000_0000, 32'd4, 4'd9);
        drv_ready = 1'b0;
        step();
        push(0, 32'd7, 32'd9, 4'd1);
        repeat (3) step();
        drv_ready = 1'b1;
        repeat (3) step();

        // Illegal op then signed compare.
        push(0, 32'd1, 32'd2, 4'hC);
        push(0, 32'hFFFF_FFFF, 32'd1, 4'd2);
        repeat (4) step();
        drain();

        // Reset while a response is pending; pointer returns to requester 0.
        push(0, 32'd11, 32'd22, 4'd0);
        step();
        drv_ready = 1'b0;
        step();
        do_reset();
        drv_ready = 1'b1;
        push(1, 32'd3, 32'd1, 4'd7);
        push(0, 32'd3, 32'd1, 4'd8);
        repeat (4) step();

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() == 0 && $urandom_range(0, 1) == 1) begin
                    push(i, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                         4'($urandom_range(0, 15)));
                end
            end
            drv_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

`ifdef ALU_ARB_PERF_EN
        drv_ready = 1'b1;
        for (int c = 0; c < 70000; c++) begin
            if (rq[0].size() == 0) push(0, $urandom, $urandom, 4'd0);
            step();
        end
        drain();
`endif

        for (int i = 0; i < N; i++) begin
            logic [IDW-1:0] ii;
            ii = IDW'(i);
`ifdef ALU_ARB_PERF_EN
            exp_cnt = (m_cnt[i] > 65535) ? 64'd65535 : 64'(m_cnt[i]);
`else
            exp_cnt = 64'd0;
`endif
            check("grant_cnt", 64'(bus.o_grant_cnt[ii]), exp_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
